// File: rtl/marquee_sequencer_if.sv
// rtl/marquee_sequencer_if.sv - sequence load port for the marquee sequencer
interface marquee_sequencer_if #(
  parameter int N = 32
) ();
  logic         load_valid;
  logic [N-1:0] load_data;
  logic         load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/marquee_sequencer.sv
// rtl/marquee_sequencer.sv - run/pause/direction control and step scheduler for the marquee
module marquee_sequencer #(
  parameter int N        = 32,
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 50_000_000,
  localparam int STEPS   = N / WIDTH,
  localparam int PW      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 dir_toggle,
  input  logic                 bounce,
  marquee_sequencer_if.slave   load,
  output logic [N-1:0]         seq_out,
  output logic [PW-1:0]        pos,
  output logic                 dir,
  output logic                 shift_en,
  output logic                 running
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [PW-1:0] pos_n;
  logic [N-1:0]  seq_reg, seq_n;
  logic          dir_n;
  logic          step;
  logic          bounce_flip;
  logic          accept;

  assign load.load_ready = (state != RUN);
  assign running         = (state == RUN);
  assign accept          = load.load_valid && load.load_ready;
  // doubling the sequence turns the right shift into a rotation
  assign seq_out         = N'(({seq_reg, seq_reg} >> (WIDTH * int'(pos))));

  // next-state, tick scheduling, step and load decisions
  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    pos_n       = pos;
    seq_n       = seq_reg;
    step        = 1'b0;
    bounce_flip = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          tick_n  = '0;
        end
      end
      RUN: begin
        // a stop on the terminal tick still lets that step complete
        if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          step   = 1'b1;
        end else if (!stop) begin
          tick_n = tick_cnt + TW'(1);
        end
        if (stop) state_n = PAUSE;
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
          pos_n   = '0;
          tick_n  = '0;
        end else if (start) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase

    // the step uses the pre-toggle direction
    if (step) begin
      if (STEPS == 1) begin
        pos_n = '0;
      end else if (bounce && dir && pos == POS_LAST) begin
        bounce_flip = 1'b1;
        pos_n       = pos - PW'(1);
      end else if (bounce && !dir && pos == '0) begin
        bounce_flip = 1'b1;
        pos_n       = PW'(1);
      end else if (dir) begin
        pos_n = (pos == POS_LAST) ? '0 : pos + PW'(1);
      end else begin
        pos_n = (pos == '0) ? POS_LAST : pos - PW'(1);
      end
    end

    if (accept) begin
      seq_n  = load.load_data;
      pos_n  = '0;
      tick_n = '0;
    end

    dir_n = dir ^ dir_toggle ^ bounce_flip;
  end

  // register state, counters, sequence and the step pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      pos      <= '0;
      seq_reg  <= '0;
      dir      <= 1'b1;
      shift_en <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      pos      <= pos_n;
      seq_reg  <= seq_n;
      dir      <= dir_n;
      shift_en <= step;
    end
  end
endmodule

// File: tb/tb_marquee_sequencer.sv
// tb/tb_marquee_sequencer.sv - scoreboard bench for marquee_sequencer
module tb_marquee_sequencer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start, stop, dir_toggle, bounce;
  logic [31:0] seq_out;
  logic [2:0]  pos;
  logic        dir, shift_en, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_steps = 0;

  typedef struct {
    int          c;
    logic [2:0]  p;
    logic        d;
    logic [31:0] s;
  } exp_t;
  exp_t q[$];

  marquee_sequencer_if #(.N(32)) lif ();

  marquee_sequencer #(.N(32), .WIDTH(4), .TICK_DIV(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .dir_toggle (dir_toggle),
    .bounce     (bounce),
    .load       (lif),
    .seq_out    (seq_out),
    .pos        (pos),
    .dir        (dir),
    .shift_en   (shift_en),
    .running    (running)
  );

  initial forever #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int d);
    return (v >> (4 * d)) | (v << (32 - 4 * d));
  endfunction

  task automatic push(input int c, input int p, input logic d, input logic [31:0] s);
    exp_t e;
    e.c = c; e.p = 3'(p); e.d = d; e.s = s;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      cycle();
      t++;
    end
    check(tag, q.size(), 0);
    q.delete();
  endtask

  // pop one expectation per step pulse and compare timing, offset, direction and data
  always @(negedge sys_clk) begin
    if (sys_rst_n && shift_en) begin
      exp_t e;
      n_steps++;
      check("step_queued", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("step_cyc", cyc, e.c);
        check("step_pos", pos, e.p);
        check("step_dir", dir, e.d);
        check("step_seq", seq_out, e.s);
      end
    end
  end

  initial begin
    int k, m, hold;
    sys_rst_n = 1'b0;
    start = 0; stop = 0; dir_toggle = 0; bounce = 0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;

    repeat (3) cycle();
    check("rst_load_ready", lif.load_ready, 1);
    check("rst_running", running, 0);
    check("rst_seq_out", seq_out, 0);
    check("rst_pos", pos, 0);
    check("rst_dir", dir, 1);
    check("rst_shift_en", shift_en, 0);
    sys_rst_n = 1'b1;
    cycle();

    lif.load_valid = 1'b1;
    lif.load_data  = 32'h7654_3210;
    check("idle_load_ready", lif.load_ready, 1);
    cycle();
    lif.load_valid = 1'b0;
    check("idle_load_seq", seq_out, 32'h7654_3210);
    check("idle_load_pos", pos, 0);

    // run right with wrap
    k = cyc;
    for (int i = 1; i <= 8; i++) push(k + 1 + 4 * i, i % 8, 1'b1, rotr(32'h7654_3210, i % 8));
    pulse_start();
    check("run_running", running, 1);
    check("run_load_ready", lif.load_ready, 0);
    drain("drain_run");
    pulse_stop();
    pulse_stop();
    check("run_idle_pos", pos, 0);
    check("run_idle_running", running, 0);

    // bounce from pos 0
    bounce = 1'b1;
    k = cyc;
    for (int i = 1; i <= 15; i++) begin
      if (i <= 7)       push(k + 1 + 4 * i, i, 1'b1, rotr(32'h7654_3210, i));
      else if (i <= 14) push(k + 1 + 4 * i, 14 - i, 1'b0, rotr(32'h7654_3210, 14 - i));
      else              push(k + 1 + 4 * i, 1, 1'b1, rotr(32'h7654_3210, 1));
    end
    pulse_start();
    drain("drain_bounce");
    pulse_stop();
    pulse_stop();
    bounce = 1'b0;
    check("bounce_idle_pos", pos, 0);

    // pause at tick 2, pos 3, then resume and return to idle
    k = cyc;
    for (int i = 1; i <= 3; i++) push(k + 1 + 4 * i, i, 1'b1, rotr(32'h7654_3210, i));
    pulse_start();
    repeat (14) cycle();
    check("pause_pre_steps", q.size(), 0);
    pulse_stop();
    hold = n_steps;
    repeat (20) cycle();
    check("pause_no_steps", n_steps, hold);
    check("pause_pos", pos, 3);
    check("pause_running", running, 0);
    m = cyc;
    push(m + 3, 4, 1'b1, rotr(32'h7654_3210, 4));
    pulse_start();
    drain("drain_resume");
    pulse_stop();
    pulse_stop();
    check("stopstop_pos", pos, 0);
    check("stopstop_ready", lif.load_ready, 1);
    check("stopstop_seq_kept", seq_out, 32'h7654_3210);

    // load gating in RUN and PAUSE
    k = cyc;
    push(k + 5, 1, 1'b1, 32'h0765_4321);
    pulse_start();
    cycle();
    lif.load_valid = 1'b1;
    lif.load_data  = 32'hFFFF_FFFF;
    check("run_load_blocked", lif.load_ready, 0);
    cycle();
    lif.load_valid = 1'b0;
    check("run_load_ignored", seq_out, 32'h7654_3210);
    drain("drain_gate");
    pulse_stop();
    check("gate_pause_pos", pos, 1);
    lif.load_valid = 1'b1;
    check("pause_load_ready", lif.load_ready, 1);
    cycle();
    lif.load_valid = 1'b0;
    check("pause_load_seq", seq_out, 32'hFFFF_FFFF);
    check("pause_load_pos", pos, 0);
    pulse_stop();
    lif.load_valid = 1'b1;
    lif.load_data  = 32'h7654_3210;
    cycle();
    lif.load_valid = 1'b0;

    // start and stop together from IDLE
    hold = n_steps;
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    repeat (6) cycle();
    check("coinc_running", running, 0);
    check("coinc_steps", n_steps, hold);

    // direction toggle on the step edge at pos 2
    k = cyc;
    push(k + 5, 1, 1'b1, rotr(32'h7654_3210, 1));
    push(k + 9, 2, 1'b1, rotr(32'h7654_3210, 2));
    push(k + 13, 3, 1'b0, rotr(32'h7654_3210, 3));
    push(k + 17, 2, 1'b0, rotr(32'h7654_3210, 2));
    pulse_start();
    repeat (11) cycle();
    dir_toggle = 1'b1;
    cycle();
    dir_toggle = 1'b0;
    drain("drain_toggle");
    pulse_stop();
    pulse_stop();
    dir_toggle = 1'b1;
    cycle();
    dir_toggle = 1'b0;
    check("idle_toggle_dir", dir, 1);

    // asynchronous reset in the middle of RUN
    k = cyc;
    push(k + 5, 1, 1'b1, 32'h0765_4321);
    pulse_start();
    drain("drain_prereset");
    cycle();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_running", running, 0);
    check("async_rst_pos", pos, 0);
    check("async_rst_seq", seq_out, 0);
    check("async_rst_dir", dir, 1);
    check("async_rst_ready", lif.load_ready, 1);
    cycle();
    sys_rst_n = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
